elevator_request_arbiter: RTL and testbench

Upstream stage of the elevator controller FSM. Captures asynchronous floor-button presses and latches them as pending requests. Clears each request when the controller reports it served, and presents one stable target floor (req_floor) to the controller. Target choice follows SCAN order: keep the current sweep direction while requests remain ahead, reverse when none remain, idle when nothing is pending.

---
 rtl/elevator_request_arbiter.sv | 146 ++++++++++++++
 tb/tb_elevator_request_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_request_arbiter.sv
// Floor-request front end for the elevator controller: synchronizes button presses,
// keeps the pending-request set, and picks a SCAN-ordered target floor.
module elevator_request_arbiter #(
  parameter  int FLOORS_NUM = 5,
  localparam int FW         = (FLOORS_NUM > 1) ? $clog2(FLOORS_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLOORS_NUM-1:0] btn_req,
  input  logic [FLOORS_NUM-1:0] request_done,
  input  logic [FW-1:0]         curr_floor,
  input  logic                  door,
  output logic [FW-1:0]         req_floor,
  output logic [FLOORS_NUM-1:0] pending,
  output logic                  dir_up,
  output logic                  dir_down
);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_state_t;

  dir_state_t            state, state_nxt;
  logic [FLOORS_NUM-1:0] btn_p0, btn_p1, btn_p2;
  logic [FLOORS_NUM-1:0] press_pulse;
  logic [FLOORS_NUM-1:0] above, below;
  logic [FW-1:0]         lo_above, hi_below;
  logic [FW:0]           dist_up, dist_dn;
  logic                  window;
  logic [FW-1:0]         req_floor_nxt;
  logic                  dir_up_nxt, dir_down_nxt;

  function automatic logic [FW-1:0] lowest_idx(input logic [FLOORS_NUM-1:0] v);
    logic [FW-1:0] idx;
    idx = '0;
    for (int i = FLOORS_NUM - 1; i >= 0; i--) begin
      if (v[i]) idx = FW'(i);
    end
    return idx;
  endfunction

  function automatic logic [FW-1:0] highest_idx(input logic [FLOORS_NUM-1:0] v);
    logic [FW-1:0] idx;
    idx = '0;
    for (int i = 0; i < FLOORS_NUM; i++) begin
      if (v[i]) idx = FW'(i);
    end
    return idx;
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2: previous synchronized level for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
      btn_p2 <= '0;
    end else begin
      btn_p0 <= btn_req;
      btn_p1 <= btn_p0;
      btn_p2 <= btn_p1;
    end
  end

  assign press_pulse = btn_p1 & ~btn_p2;

  // Pending set: a clear on the same edge as a press wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending | press_pulse) & ~request_done;
    end
  end

  always_comb begin
    above = '0;
    below = '0;
    for (int i = 0; i < FLOORS_NUM; i++) begin
      above[i] = pending[i] && (FW'(i) > curr_floor);
      below[i] = pending[i] && (FW'(i) < curr_floor);
    end
  end

  assign lo_above = lowest_idx(above);
  assign hi_below = highest_idx(below);
  assign dist_up  = {1'b0, lo_above} - {1'b0, curr_floor};
  assign dist_dn  = {1'b0, curr_floor} - {1'b0, hi_below};

  // Only re-target once the car has arrived and the door cycle is complete
  assign window = (curr_floor == req_floor) && !door && (request_done == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DIR_IDLE;
      req_floor <= '0;
      dir_up    <= 1'b0;
      dir_down  <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_floor <= req_floor_nxt;
      dir_up    <= dir_up_nxt;
      dir_down  <= dir_down_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (window) begin
      unique case (state)
        DIR_IDLE: begin
          if (|above && |below) state_nxt = (dist_up <= dist_dn) ? DIR_UP : DIR_DOWN;
          else if (|above)      state_nxt = DIR_UP;
          else if (|below)      state_nxt = DIR_DOWN;
          else                  state_nxt = DIR_IDLE;
        end
        DIR_UP: begin
          if (|above)      state_nxt = DIR_UP;
          else if (|below) state_nxt = DIR_DOWN;
          else             state_nxt = DIR_IDLE;
        end
        DIR_DOWN: begin
          if (|below)      state_nxt = DIR_DOWN;
          else if (|above) state_nxt = DIR_UP;
          else             state_nxt = DIR_IDLE;
        end
        default: state_nxt = DIR_IDLE;
      endcase
    end
  end

  always_comb begin
    req_floor_nxt = req_floor;
    dir_up_nxt    = (state_nxt == DIR_UP);
    dir_down_nxt  = (state_nxt == DIR_DOWN);
    if (window) begin
      unique case (state_nxt)
        DIR_UP:   req_floor_nxt = lo_above;
        DIR_DOWN: req_floor_nxt = hi_below;
        default:  req_floor_nxt = curr_floor;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_request_arbiter.sv
// Scoreboard bench for elevator_request_arbiter: expectations are queued with each
// stimulus step and compared against the DUT after the corresponding clock edge.
module tb_elevator_request_arbiter;

  localparam int FLOORS_NUM = 5;
  localparam int FW = 3;

  logic                  clk;
  logic                  rst_n;
  logic [FLOORS_NUM-1:0] btn_req;
  logic [FLOORS_NUM-1:0] request_done;
  logic [FW-1:0]         curr_floor;
  logic                  door;
  logic [FW-1:0]         req_floor;
  logic [FLOORS_NUM-1:0] pending;
  logic                  dir_up;
  logic                  dir_down;

  int n_checks = 0;
  int n_errors = 0;

  string       q_tag[$];
  int          q_sel[$];
  logic [31:0] q_exp[$];

  elevator_request_arbiter #(.FLOORS_NUM(FLOORS_NUM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_req      (btn_req),
    .request_done (request_done),
    .curr_floor   (curr_floor),
    .door         (door),
    .req_floor    (req_floor),
    .pending      (pending),
    .dir_up       (dir_up),
    .dir_down     (dir_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int sel, input logic [31:0] exp);
    q_tag.push_back(tag);
    q_sel.push_back(sel);
    q_exp.push_back(exp);
  endtask

  task automatic expect_state(input string tag, input logic [4:0] p, input int r,
                              input logic u, input logic d);
    sb_push({tag, ".pending"},  0, 32'(p));
    sb_push({tag, ".req_floor"}, 1, 32'(r));
    sb_push({tag, ".dir_up"},   2, 32'(u));
    sb_push({tag, ".dir_down"}, 3, 32'(d));
  endtask

  task automatic sb_drain();
    logic [31:0] obs;
    while (q_tag.size() > 0) begin
      case (q_sel[0])
        0:       obs = 32'(pending);
        1:       obs = 32'(req_floor);
        2:       obs = 32'(dir_up);
        default: obs = 32'(dir_down);
      endcase
      check_val(q_tag[0], obs, q_exp[0]);
      void'(q_tag.pop_front());
      void'(q_sel.pop_front());
      void'(q_exp.pop_front());
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic serve(input int floor);
    curr_floor   = FW'(floor);
    door         = 1'b1;
    request_done = FLOORS_NUM'(1) << floor;
    tick(1);
    request_done = '0;
    door         = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    btn_req      = '0;
    request_done = '0;
    curr_floor   = '0;
    door         = 1'b0;
    tick(2);
    expect_state("reset", 5'b00000, 0, 1'b0, 1'b0);
    sb_drain();
    rst_n = 1'b1;

    // single press, three-edge capture then target on the next edge
    btn_req = 5'b01000;
    tick(2);
    expect_state("cap_e2", 5'b00000, 0, 1'b0, 1'b0);
    sb_drain();
    tick(1);
    expect_state("cap_e3", 5'b01000, 0, 1'b0, 1'b0);
    sb_drain();
    tick(1);
    expect_state("cap_e4", 5'b01000, 3, 1'b1, 1'b0);
    sb_drain();
    btn_req = '0;
    serve(3);
    expect_state("serve3_door", 5'b00000, 3, 1'b1, 1'b0);
    sb_drain();
    tick(1);
    expect_state("idle_at3", 5'b00000, 3, 1'b0, 1'b0);
    sb_drain();

    // held button yields one request; clearing it while held keeps it clear
    btn_req = 5'b00100;
    tick(3);
    expect_state("hold_set", 5'b00100, 3, 1'b0, 1'b0);
    sb_drain();
    tick(1);
    expect_state("hold_down", 5'b00100, 2, 1'b0, 1'b1);
    sb_drain();
    tick(20);
    sb_push("hold_still", 0, 32'(5'b00100));
    sb_drain();
    serve(2);
    tick(1);
    expect_state("hold_cleared", 5'b00000, 2, 1'b0, 1'b0);
    sb_drain();
    tick(24);
    sb_push("hold_no_repulse", 0, 32'(5'b00000));
    sb_drain();
    btn_req = '0;
    tick(4);
    btn_req = 5'b00100;
    tick(3);
    sb_push("repress_set", 0, 32'(5'b00100));
    sb_drain();
    btn_req = '0;
    tick(2);
    expect_state("at_floor_idle", 5'b00100, 2, 1'b0, 1'b0);
    sb_drain();
    serve(2);
    tick(1);

    // equal distance from floor 2 to floors 0 and 4 goes up first
    btn_req = 5'b10001;
    tick(3);
    sb_push("tie_pending", 0, 32'(5'b10001));
    sb_drain();
    tick(1);
    expect_state("tie_up", 5'b10001, 4, 1'b1, 1'b0);
    sb_drain();
    btn_req = '0;
    serve(4);
    sb_push("tie_serve4", 0, 32'(5'b00001));
    sb_drain();
    tick(1);
    expect_state("reverse_down", 5'b00001, 0, 1'b0, 1'b1);
    sb_drain();

    // target holds while travelling even when a nearer floor is pressed
    serve(0);
    tick(1);
    expect_state("idle_at0", 5'b00000, 0, 1'b0, 1'b0);
    sb_drain();
    btn_req = 5'b10000;
    tick(4);
    expect_state("trip_up4", 5'b10000, 4, 1'b1, 1'b0);
    sb_drain();
    btn_req    = 5'b01000;
    curr_floor = 3'd1;
    tick(3);
    btn_req = '0;
    tick(3);
    expect_state("trip_hold", 5'b11000, 4, 1'b1, 1'b0);
    sb_drain();
    curr_floor = 3'd3;
    tick(2);
    sb_push("trip_pass3", 1, 32'(4));
    sb_drain();
    serve(4);
    expect_state("trip_door4", 5'b01000, 4, 1'b1, 1'b0);
    sb_drain();
    tick(1);
    expect_state("trip_back3", 5'b01000, 3, 1'b0, 1'b1);
    sb_drain();

    // press pulse and clear on the same edge leave the bit clear
    serve(3);
    tick(1);
    expect_state("idle_at3b", 5'b00000, 3, 1'b0, 1'b0);
    sb_drain();
    btn_req = 5'b01000;
    tick(2);
    request_done = 5'b01000;
    door         = 1'b1;
    tick(1);
    sb_push("same_edge_clear", 0, 32'(5'b00000));
    sb_drain();
    request_done = '0;
    door         = 1'b0;
    tick(3);
    sb_push("same_edge_held", 0, 32'(5'b00000));
    sb_drain();
    btn_req = '0;
    tick(3);

    // asynchronous reset mid-trip, then normal capture
    btn_req = 5'b11010;
    tick(3);
    sb_push("pre_rst_pending", 0, 32'(5'b11010));
    sb_drain();
    tick(1);
    expect_state("pre_rst_up", 5'b11010, 4, 1'b1, 1'b0);
    sb_drain();
    btn_req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("async_rst", 5'b00000, 0, 1'b0, 1'b0);
    sb_drain();
    tick(2);
    rst_n      = 1'b1;
    curr_floor = 3'd0;
    tick(1);
    btn_req = 5'b00010;
    tick(3);
    sb_push("post_rst_pending", 0, 32'(5'b00010));
    sb_drain();
    tick(1);
    expect_state("post_rst_up", 5'b00010, 1, 1'b1, 1'b0);
    sb_drain();
    btn_req = '0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
